instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/tb4004_pkg.sv | 18 +
 rtl/cond_eval.sv | 10 +
 rtl/instr_sequencer.sv | 115 +++++++++++
 tb/tb_instr_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tb4004_pkg.sv
// tb4004_pkg: opcodes, machine-cycle indices and sequencer state shared by the 4004 fetch/sequence logic
package tb4004_pkg;
  localparam logic [3:0] OPR_JCN     = 4'd1;
  localparam logic [3:0] OPR_FIM_SRC = 4'd2;
  localparam logic [3:0] OPR_FIN_JIN = 4'd3;
  localparam logic [3:0] OPR_JUN     = 4'd4;
  localparam logic [3:0] OPR_JMS     = 4'd5;
  localparam logic [3:0] OPR_ISZ     = 4'd7;
  localparam logic [3:0] OPR_BBL     = 4'd12;
  localparam logic [2:0] CYC_M1 = 3'd3;
  localparam logic [2:0] CYC_M2 = 3'd4;
  localparam logic [2:0] CYC_X1 = 3'd5;
  typedef enum logic {FIRST, SECOND} seqState_t;
  function automatic logic isTwoWord(input logic [3:0] opr, input logic [3:0] opa);
    return opr == OPR_JCN || (opr == OPR_FIM_SRC && !opa[0]) || opr == OPR_JUN ||
           opr == OPR_JMS || opr == OPR_ISZ;
  endfunction
endpackage

// File: rtl/cond_eval.sv
// cond_eval: JCN jump condition; opa[3] inverts, opa[2:0] select accZero, carryFlag, ~testIn
module cond_eval (
  input  logic [3:0] opa,
  input  logic       accZero,
  input  logic       carryFlag,
  input  logic       testIn,
  output logic       jump
);
  assign jump = opa[3] ^ |(opa[2:0] & {accZero, carryFlag, ~testIn});
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: latches OPR/OPA, sequences one- and two-word instructions at X1
// Optional JCN jumping enabled by macro TB4004_SEQ_JCN_EN.
module instr_sequencer
  import tb4004_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cycle,
  input  logic [3:0]  romNibble,
  input  logic [11:0] pcAddr,
  input  logic [7:0]  pairDout,
  input  logic        accZero,
  input  logic        carryFlag,
  input  logic        testIn,
  output logic [3:0]  oprOut,
  output logic [3:0]  opaOut,
  output logic        secondWord,
  output logic        instrValid,
  output logic        pcLoad,
  output logic [11:0] pcNew,
  output logic        stackPush,
  output logic        stackPop,
  output logic        pairWe,
  output logic [3:0]  pairAddr,
  output logic [7:0]  pairDin
);
  seqState_t state, stateNext;
  logic [3:0] opr1, opa1, opr1Next, opa1Next, pairAddrNext;
  logic [7:0] byteVal, pairDinNext;
  logic [11:0] pcNewNext;
  logic ivNext, plNext, pushNext, popNext, weNext, jcnTake;
  logic unusedPc;
  assign unusedPc = &{1'b0, pcAddr[7:0]};
  assign byteVal = {oprOut, opaOut};
  assign secondWord = state == SECOND;
`ifdef TB4004_SEQ_JCN_EN
  cond_eval uCond (
    .opa(opa1),
    .accZero(accZero),
    .carryFlag(carryFlag),
    .testIn(testIn),
    .jump(jcnTake)
  );
`else
  logic unusedCond;
  assign unusedCond = &{1'b0, accZero, carryFlag, testIn};
  assign jcnTake = 1'b0;
`endif
  always_comb begin
    stateNext = state;
    opr1Next = opr1;
    opa1Next = opa1;
    pcNewNext = pcNew;
    pairAddrNext = pairAddr;
    pairDinNext = pairDin;
    ivNext = 1'b0;
    plNext = 1'b0;
    pushNext = 1'b0;
    popNext = 1'b0;
    weNext = 1'b0;
    if (cycle == CYC_X1 && state == FIRST) begin
      if (isTwoWord(oprOut, opaOut)) begin
        stateNext = SECOND;
        opr1Next = oprOut;
        opa1Next = opaOut;
      end else if (oprOut == OPR_FIN_JIN && opaOut[0]) begin
        plNext = 1'b1;
        pcNewNext = {pcAddr[11:8], pairDout};
      end else begin
        ivNext = 1'b1;
        popNext = oprOut == OPR_BBL;
      end
    end else if (cycle == CYC_X1) begin
      stateNext = FIRST;
      plNext = opr1 == OPR_JUN || opr1 == OPR_JMS || (opr1 == OPR_JCN && jcnTake);
      pushNext = opr1 == OPR_JMS;
      weNext = opr1 == OPR_FIM_SRC;
      // JCN stays in the current page; JUN/JMS take the page from the first word
      pcNewNext = !plNext ? pcNew : opr1 == OPR_JCN ? {pcAddr[11:8], byteVal} : {opa1, byteVal};
      pairAddrNext = weNext ? {opa1[3:1], 1'b0} : pairAddr;
      pairDinNext = weNext ? byteVal : pairDin;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FIRST;
      oprOut <= '0;
      opaOut <= '0;
      opr1 <= '0;
      opa1 <= '0;
      pcNew <= '0;
      pairAddr <= '0;
      pairDin <= '0;
      instrValid <= 1'b0;
      pcLoad <= 1'b0;
      stackPush <= 1'b0;
      stackPop <= 1'b0;
      pairWe <= 1'b0;
    end else begin
      state <= stateNext;
      oprOut <= cycle == CYC_M1 ? romNibble : oprOut;
      opaOut <= cycle == CYC_M2 ? romNibble : opaOut;
      opr1 <= opr1Next;
      opa1 <= opa1Next;
      pcNew <= pcNewNext;
      pairAddr <= pairAddrNext;
      pairDin <= pairDinNext;
      instrValid <= ivNext;
      pcLoad <= plNext;
      stackPush <= pushNext;
      stackPop <= popNext;
      pairWe <= weNext;
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed and random instruction words checked against an instruction-level model
module tb_instr_sequencer;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] cycle = '0;
  logic [3:0] romNibble = '0;
  logic [11:0] pcAddr = '0;
  logic [7:0] pairDout = '0;
  logic accZero = 1'b0, carryFlag = 1'b0, testIn = 1'b1;
  logic [3:0] oprOut, opaOut, pairAddr;
  logic secondWord, instrValid, pcLoad, stackPush, stackPop, pairWe;
  logic [11:0] pcNew;
  logic [7:0] pairDin;
  int total = 0, bad = 0;
  bit mPend = 0;
  logic [3:0] mOpr1 = '0, mOpa1 = '0, mPairAddr = '0, eOpr = '0, eOpa = '0;
  logic [11:0] mPcNew = '0;
  logic [7:0] mPairDin = '0;
  bit eIv, ePl, ePush, ePop, eWe;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .cycle(cycle), .romNibble(romNibble), .pcAddr(pcAddr),
    .pairDout(pairDout), .accZero(accZero), .carryFlag(carryFlag), .testIn(testIn),
    .oprOut(oprOut), .opaOut(opaOut), .secondWord(secondWord), .instrValid(instrValid),
    .pcLoad(pcLoad), .pcNew(pcNew), .stackPush(stackPush), .stackPop(stackPop),
    .pairWe(pairWe), .pairAddr(pairAddr), .pairDin(pairDin)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // instruction-level view: what the sequencer must do at the X1 of this word
  task automatic modelX1(input logic [3:0] opr, input logic [3:0] opa, input bit r);
    logic [7:0] b;
    bit jcnTrue;
    {eIv, ePl, ePush, ePop, eWe} = '0;
    b = {opr, opa};
    jcnTrue = ((mOpa1[2] && accZero) || (mOpa1[1] && carryFlag) || (mOpa1[0] && !testIn)) != mOpa1[3];
    eOpr = r ? 4'h0 : opr;
    eOpa = r ? 4'h0 : opa;
    if (r) begin
      mPend = 0; mPcNew = '0; mPairAddr = '0; mPairDin = '0;
    end else if (!mPend) begin
      if (opr inside {4'd1, 4'd4, 4'd5, 4'd7} || (opr == 4'd2 && !opa[0])) begin
        mPend = 1; mOpr1 = opr; mOpa1 = opa;
      end else if (opr == 4'd3 && opa[0]) begin
        ePl = 1; mPcNew = {pcAddr[11:8], pairDout};
      end else begin
        eIv = 1; ePop = opr == 4'd12;
      end
    end else begin
      mPend = 0;
      if (mOpr1 == 4'd4 || mOpr1 == 4'd5) begin
        ePl = 1; ePush = mOpr1 == 4'd5; mPcNew = {mOpa1, b};
      end else if (mOpr1 == 4'd2) begin
        eWe = 1; mPairAddr = mOpa1 & 4'hE; mPairDin = b;
      end else if (mOpr1 == 4'd1) begin
`ifdef TB4004_SEQ_JCN_EN
        if (jcnTrue) begin ePl = 1; mPcNew = {pcAddr[11:8], b}; end
`endif
      end
    end
  endtask

  task automatic runWord(input logic [3:0] opr, input logic [3:0] opa, input bit rstX1);
    for (int k = 0; k < 8; k++) begin
      cycle = 3'(k);
      romNibble = k == 3 ? opr : k == 4 ? opa : 4'($urandom);
      rst = rstX1 && k == 5;
      if (k == 5) modelX1(opr, opa, rstX1);
      @(posedge clk);
      #1;
      if (k == 5) begin
        chk("instrValid", instrValid, eIv);
        chk("pcLoad", pcLoad, ePl);
        chk("stackPush", stackPush, ePush);
        chk("stackPop", stackPop, ePop);
        chk("pairWe", pairWe, eWe);
        chk("secondWord", secondWord, mPend);
        chk("pcNew", pcNew, mPcNew);
        chk("pairAddr", pairAddr, mPairAddr);
        chk("pairDin", pairDin, mPairDin);
        chk("oprOut", oprOut, eOpr);
        chk("opaOut", opaOut, eOpa);
      end
      if (k == 6) begin
        chk("pulseWidth", {instrValid, pcLoad, stackPush, stackPop, pairWe}, 0);
        chk("pcNewHold", pcNew, mPcNew);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rstPulses", {instrValid, pcLoad, stackPush, stackPop, pairWe, secondWord}, 0);
    chk("rstOpr", oprOut, 0);
    chk("rstOpa", opaOut, 0);
    chk("rstPcNew", pcNew, 0);
    chk("rstPair", {pairAddr, pairDin}, 0);
    rst = 1'b0;
    runWord(4'h4, 4'h3, 0);
    runWord(4'h2, 4'h1, 0);
    chk("junTarget", pcNew, 12'h321);
    pcAddr = 12'h102;
    runWord(4'h5, 4'h0, 0);
    runWord(4'hA, 4'hB, 0);
    chk("jmsTarget", pcNew, 12'h0AB);
    pcAddr = 12'h2FF; accZero = 1; carryFlag = 0; testIn = 1;
    runWord(4'h1, 4'h4, 0);
    runWord(4'h7, 4'h7, 0);
`ifdef TB4004_SEQ_JCN_EN
    chk("jcnTarget", pcNew, 12'h277);
`endif
    accZero = 0;
    runWord(4'h1, 4'h4, 0);
    runWord(4'h7, 4'h7, 0);
    runWord(4'h1, 4'hC, 0);
    runWord(4'h7, 4'h7, 0);
    runWord(4'h2, 4'h6, 0);
    runWord(4'h5, 4'hA, 0);
    chk("fimAddr", pairAddr, 4'h6);
    chk("fimData", pairDin, 8'h5A);
    pairDout = 8'h44; pcAddr = 12'h512;
    runWord(4'h3, 4'h7, 0);
    chk("jinTarget", pcNew, 12'h544);
    runWord(4'h4, 4'h1, 0);
    runWord(4'h9, 4'h9, 1);
    runWord(4'hD, 4'h0, 0);
    runWord(4'hC, 4'h3, 0);
    for (int i = 0; i < 300; i++) begin
      pcAddr = 12'($urandom);
      pairDout = 8'($urandom);
      {accZero, carryFlag, testIn} = 3'($urandom);
      runWord(4'($urandom), 4'($urandom), $urandom_range(0, 19) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
